// File: rtl/wb_arbiter_rr.sv
// -----------------------------------------------------------------------------
// wb_arbiter_rr
//
// Arbitrates N_MST masters onto one Wishbone master port. A single bus cycle is
// in flight at a time: IDLE picks a winner and latches its request, BUS holds
// cyc/stb until wb_ack_i or a wait timeout, DONE inserts one idle bus cycle
// before the next grant.
//
// Configuration macro:
//   WB_ARB_ROUND_ROBIN_EN  defined   -> round-robin grant starting after the
//                                       last granted index
//                          undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   flush_i                cancels the response of the bus cycle in flight
//   m_req/m_we             per-master request and write enable
//   m_addr/m_wdata/m_sel   packed per-master address, write data, byte selects
//   m_rdata                registered read data, valid while m_ack is high
//   m_ack/m_err            one-hot one-cycle completion / timeout pulses
//   m_stall                m_req & ~m_ack & ~m_err (combinational)
//   wb_*_o                 registered Wishbone master outputs
//   wb_dat_i, wb_ack_i     Wishbone read data and acknowledge
//
// Handshake: a master holds m_req (and its attributes) high until it sees its
// m_ack or m_err bit; the arbiter samples the attributes only on the grant
// edge, so later changes to m_req/attributes do not affect the cycle in flight.
// -----------------------------------------------------------------------------
module wb_arbiter_rr #(
   parameter int N_MST   = 2,
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int TIMEOUT = 255,
   localparam int SW     = DW / 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush_i,
   input  logic [N_MST-1:0]    m_req,
   input  logic [N_MST-1:0]    m_we,
   input  logic [N_MST*AW-1:0] m_addr,
   input  logic [N_MST*DW-1:0] m_wdata,
   input  logic [N_MST*SW-1:0] m_sel,
   output logic [DW-1:0]       m_rdata,
   output logic [N_MST-1:0]    m_ack,
   output logic [N_MST-1:0]    m_err,
   output logic [N_MST-1:0]    m_stall,
   output logic                wb_cyc_o,
   output logic                wb_stb_o,
   output logic                wb_we_o,
   output logic [AW-1:0]       wb_adr_o,
   output logic [DW-1:0]       wb_dat_o,
   output logic [SW-1:0]       wb_sel_o,
   input  logic [DW-1:0]       wb_dat_i,
   input  logic                wb_ack_i
);

   localparam int          GW        = (N_MST > 1) ? $clog2(N_MST) : 1;
   localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              cancel_q, cancel_d;
   logic [GW-1:0]     grant_q, grant_d;
   logic              cyc_q, cyc_d;
   logic              we_q, we_d;
   logic [AW-1:0]     adr_q, adr_d;
   logic [DW-1:0]     dat_q, dat_d;
   logic [SW-1:0]     sel_q, sel_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic [N_MST-1:0]  ack_q, ack_d;
   logic [N_MST-1:0]  err_q, err_d;

   logic [GW-1:0]     win;
   logic [GW-1:0]     cand;
   logic              win_we;
   logic [AW-1:0]     win_adr;
   logic [DW-1:0]     win_dat;
   logic [SW-1:0]     win_sel;
   logic [N_MST-1:0]  grant_oh;
   logic [15:0]       cnt_inc;
   logic              cancel_now;

`ifdef WB_ARB_ROUND_ROBIN_EN
   logic [GW-1:0]     ptr_q, ptr_d;
   logic              found;

   // Search upward from the master after the last grant, wrapping around.
   always_comb begin
      win   = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 1; k <= N_MST; k++) begin
         cand = GW'((int'(ptr_q) + k) % N_MST);
         if (!found && m_req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end
`else
   // Lowest index wins: scan downward so the last hit is the smallest index.
   always_comb begin
      win  = '0;
      cand = '0;
      for (int k = N_MST - 1; k >= 0; k--) begin
         cand = GW'(k);
         if (m_req[cand]) win = cand;
      end
   end
`endif

   // Attributes of the current winner, sampled only on the grant edge.
   always_comb begin
      win_we  = 1'b0;
      win_adr = '0;
      win_dat = '0;
      win_sel = '0;
      for (int i = 0; i < N_MST; i++) begin
         if (win == GW'(i)) begin
            win_we  = m_we[i];
            win_adr = m_addr[i*AW +: AW];
            win_dat = m_wdata[i*DW +: DW];
            win_sel = m_sel[i*SW +: SW];
         end
      end
   end

   always_comb begin
      grant_oh = '0;
      for (int i = 0; i < N_MST; i++) grant_oh[i] = (grant_q == GW'(i));
   end

   assign cnt_inc    = cnt_q + 16'd1;
   // A flush in the final bus cycle still cancels that cycle's response.
   assign cancel_now = cancel_q | flush_i;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cancel_d = cancel_q;
      grant_d  = grant_q;
      cyc_d    = cyc_q;
      we_d     = we_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      sel_d    = sel_q;
      rdata_d  = rdata_q;
      ack_d    = '0;
      err_d    = '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
      ptr_d    = ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            cnt_d    = '0;
            cancel_d = 1'b0;
            if (|m_req) begin
               grant_d = win;
               cyc_d   = 1'b1;
               we_d    = win_we;
               adr_d   = win_adr;
               dat_d   = win_dat;
               sel_d   = win_sel;
               state_d = ST_BUS;
`ifdef WB_ARB_ROUND_ROBIN_EN
               ptr_d   = win;
`endif
            end
         end
         ST_BUS: begin
            if (flush_i) cancel_d = 1'b1;
            // Ack wins over a timeout landing in the same cycle.
            if (wb_ack_i) begin
               cyc_d   = 1'b0;
               state_d = ST_DONE;
               if (!cancel_now) begin
                  rdata_d = wb_dat_i;
                  ack_d   = grant_oh;
               end
            end else if (cnt_inc == TIMEOUT_C) begin
               cnt_d   = cnt_inc;
               cyc_d   = 1'b0;
               state_d = ST_DONE;
               if (!cancel_now) err_d = grant_oh;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_DONE: begin
            cnt_d    = '0;
            cancel_d = 1'b0;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cyc_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         cancel_q <= 1'b0;
         grant_q  <= '0;
         cyc_q    <= 1'b0;
         we_q     <= 1'b0;
         adr_q    <= '0;
         dat_q    <= '0;
         sel_q    <= '0;
         rdata_q  <= '0;
         ack_q    <= '0;
         err_q    <= '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
         ptr_q    <= GW'(N_MST - 1);
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cancel_q <= cancel_d;
         grant_q  <= grant_d;
         cyc_q    <= cyc_d;
         we_q     <= we_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         sel_q    <= sel_d;
         rdata_q  <= rdata_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
`ifdef WB_ARB_ROUND_ROBIN_EN
         ptr_q    <= ptr_d;
`endif
      end
   end

   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = cyc_q;
   assign wb_we_o  = we_q;
   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;
   assign wb_sel_o = sel_q;
   assign m_rdata  = rdata_q;
   assign m_ack    = ack_q;
   assign m_err    = err_q;
   assign m_stall  = m_req & ~ack_q & ~err_q;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter_rr
//
// Self-checking bench for wb_arbiter_rr (N_MST=3, DW=AW=32, TIMEOUT=4).
// Directed scenarios plus a randomized transaction loop checked against a
// transaction-level model: grant choice from the arbitration rule, completion
// cycle from the slave latency and TIMEOUT, response suppression from flush.
// Inputs change on the falling edge; outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_wb_arbiter_rr;

   localparam int N_MST   = 3;
   localparam int DW      = 32;
   localparam int AW      = 32;
   localparam int SW      = DW / 8;
   localparam int TIMEOUT = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic                flush_i = 1'b0;
   logic [N_MST-1:0]    m_req, m_we;
   logic [N_MST*AW-1:0] m_addr;
   logic [N_MST*DW-1:0] m_wdata;
   logic [N_MST*SW-1:0] m_sel;
   logic [DW-1:0]       m_rdata;
   logic [N_MST-1:0]    m_ack, m_err, m_stall;
   logic                wb_cyc_o, wb_stb_o, wb_we_o;
   logic [AW-1:0]       wb_adr_o;
   logic [DW-1:0]       wb_dat_o;
   logic [SW-1:0]       wb_sel_o;
   logic [DW-1:0]       wb_dat_i = '0;
   logic                wb_ack_i = 1'b0;

   wb_arbiter_rr #(.N_MST(N_MST), .DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_sel(m_sel),
      .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err), .m_stall(m_stall),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [DW-1:0] exp_q[$];

   // Per-master pending transaction table (drives m_req and attributes).
   logic [N_MST-1:0] pend = '0;
   logic             t_we  [N_MST];
   logic [AW-1:0]    t_adr [N_MST];
   logic [DW-1:0]    t_dat [N_MST];
   logic [SW-1:0]    t_sel [N_MST];

   int            last_g      = N_MST - 1;  // index granted most recently
   logic [DW-1:0] model_rdata = '0;

   // ---------------- driver tasks ----------------
   task automatic drive_masters();
      for (int i = 0; i < N_MST; i++) begin
         m_req[i]               = pend[i];
         m_we[i]                = t_we[i];
         m_addr[i*AW +: AW]     = t_adr[i];
         m_wdata[i*DW +: DW]    = t_dat[i];
         m_sel[i*SW +: SW]      = t_sel[i];
      end
   endtask

   task automatic new_txn(input int i);
      pend[i]  = 1'b1;
      t_we[i]  = 1'($urandom_range(0, 1));
      t_adr[i] = $urandom;
      t_dat[i] = $urandom;
      t_sel[i] = SW'($urandom_range(1, (1 << SW) - 1));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; pend = '0; flush_i = 1'b0; wb_ack_i = 1'b0;
      drive_masters();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      last_g = N_MST - 1;
      model_rdata = '0;
   endtask

   // Arbitration rule at transaction level.
   function automatic int model_pick(input logic [N_MST-1:0] req);
`ifdef WB_ARB_ROUND_ROBIN_EN
      for (int k = 1; k <= N_MST; k++)
         if (req[(last_g + k) % N_MST]) return (last_g + k) % N_MST;
`else
      for (int i = 0; i < N_MST; i++)
         if (req[i]) return i;
`endif
      return -1;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; flush_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = $urandom;
      for (int i = 0; i < N_MST; i++) new_txn(i);
      drive_masters();
      @(negedge clk);
      n_checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl: got %b want 000", {wb_cyc_o, wb_stb_o, wb_we_o}); end
      n_checks++; if ({wb_adr_o, wb_dat_o, wb_sel_o} !== '0) begin n_fail++; $display("FAIL reset_bus: got %h/%h/%h want 0", wb_adr_o, wb_dat_o, wb_sel_o); end
      n_checks++; if ({m_rdata, m_ack, m_err} !== '0) begin n_fail++; $display("FAIL reset_resp: got %h/%b/%b want 0", m_rdata, m_ack, m_err); end
      n_checks++; if (m_stall !== pend) begin n_fail++; $display("FAIL reset_stall: got %b want %b", m_stall, pend); end
      rst = 1'b0; pend = '0; flush_i = 1'b0; wb_ack_i = 1'b0;
      drive_masters();
      @(negedge clk);
      n_checks++; if (wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got %b want 0", wb_cyc_o); end
      last_g = N_MST - 1;
      model_rdata = '0;
   endtask

   task automatic test_single_read();
      pend = '0; pend[0] = 1'b1; t_we[0] = 1'b0; t_adr[0] = 32'h0000_0100; t_sel[0] = 4'hF; t_dat[0] = 32'h0;
      drive_masters();
      n_checks++; if (wb_stb_o !== 1'b0) begin n_fail++; $display("FAIL sr_stb_c0: got %b want 0", wb_stb_o); end
      @(negedge clk);  // cycle 1
      n_checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b110) begin n_fail++; $display("FAIL sr_stb_c1: got %b want 110", {wb_cyc_o, wb_stb_o, wb_we_o}); end
      n_checks++; if (wb_adr_o !== 32'h0000_0100) begin n_fail++; $display("FAIL sr_adr: got %h want 00000100", wb_adr_o); end
      for (int c = 2; c <= 4; c++) begin
         @(negedge clk);
         n_checks++; if (wb_cyc_o !== 1'b1 || m_ack !== '0) begin n_fail++; $display("FAIL sr_wait_c%0d: cyc %b ack %b want 1/000", c, wb_cyc_o, m_ack); end
      end
      n_checks++; if (m_stall !== 3'b001) begin n_fail++; $display("FAIL sr_stall: got %b want 001", m_stall); end
      wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
      @(negedge clk);  // cycle 5
      wb_ack_i = 1'b0;
      n_checks++; if (m_ack !== 3'b001) begin n_fail++; $display("FAIL sr_ack_c5: got %b want 001", m_ack); end
      n_checks++; if (m_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sr_rdata: got %h want deadbeef", m_rdata); end
      n_checks++; if (wb_cyc_o !== 1'b0 || m_stall !== 3'b000) begin n_fail++; $display("FAIL sr_end: cyc %b stall %b want 0/000", wb_cyc_o, m_stall); end
      pend = '0; drive_masters();
      @(negedge clk);
      n_checks++; if (m_ack !== '0) begin n_fail++; $display("FAIL sr_pulse: got %b want 000", m_ack); end
   endtask

   task automatic test_contention();
      int               ord[4];
      logic [N_MST-1:0] oh;
`ifdef WB_ARB_ROUND_ROBIN_EN
      ord = '{0, 1, 0, 1};
`else
      ord = '{0, 0, 0, 0};
`endif
      do_reset();
      pend = 3'b011;
      t_we[0] = 1'b0; t_adr[0] = 32'h0000_1000; t_sel[0] = 4'hF; t_dat[0] = 32'h0;
      t_we[1] = 1'b0; t_adr[1] = 32'h0000_2000; t_sel[1] = 4'hF; t_dat[1] = 32'h0;
      drive_masters();
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);  // BUS
         n_checks++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== t_adr[ord[t]]) begin n_fail++; $display("FAIL cont_grant%0d: cyc %b adr %h want 1/%h", t, wb_cyc_o, wb_adr_o, t_adr[ord[t]]); end
         wb_ack_i = 1'b1; wb_dat_i = 32'hC0DE_0000 + 32'(t);
         @(negedge clk);  // DONE
         wb_ack_i = 1'b0;
         oh = '0; oh[ord[t]] = 1'b1;
         n_checks++; if (m_ack !== oh || m_rdata !== 32'hC0DE_0000 + 32'(t)) begin n_fail++; $display("FAIL cont_ack%0d: ack %b rdata %h want %b/%h", t, m_ack, m_rdata, oh, 32'hC0DE_0000 + 32'(t)); end
         if (t == 3) begin pend = '0; drive_masters(); end
         @(negedge clk);  // IDLE gap
         n_checks++; if (wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL cont_gap%0d: got %b want 0", t, wb_cyc_o); end
      end
   endtask

   task automatic test_timeout();
      pend = '0; pend[1] = 1'b1; t_we[1] = 1'b0; t_adr[1] = 32'h0000_0200;
      drive_masters();
      for (int c = 1; c <= TIMEOUT; c++) begin
         @(negedge clk);
         n_checks++; if (wb_cyc_o !== 1'b1 || m_err !== '0 || m_ack !== '0) begin n_fail++; $display("FAIL to_wait_c%0d: cyc %b err %b ack %b want 1/000/000", c, wb_cyc_o, m_err, m_ack); end
      end
      @(negedge clk);
      n_checks++; if (wb_cyc_o !== 1'b0 || m_err !== 3'b010 || m_ack !== '0) begin n_fail++; $display("FAIL to_err: cyc %b err %b ack %b want 0/010/000", wb_cyc_o, m_err, m_ack); end
      pend = '0; drive_masters();
      @(negedge clk);
      n_checks++; if (m_err !== '0 || wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL to_after: err %b cyc %b want 000/0", m_err, wb_cyc_o); end
   endtask

   task automatic test_flush();
      do_reset();
      pend = '0; pend[1] = 1'b1;
      t_we[1] = 1'b1; t_sel[1] = 4'b0011; t_dat[1] = 32'h1234_5678; t_adr[1] = 32'h0000_0300;
      drive_masters();
      @(negedge clk);  // BUS 1
      n_checks++; if ({wb_cyc_o, wb_we_o, wb_sel_o} !== {1'b1, 1'b1, 4'b0011} || wb_dat_o !== 32'h1234_5678) begin n_fail++; $display("FAIL fl_bus: cyc %b we %b sel %b dat %h want 1/1/0011/12345678", wb_cyc_o, wb_we_o, wb_sel_o, wb_dat_o); end
      flush_i = 1'b1;
      @(negedge clk);  // BUS 2
      flush_i = 1'b0;
      n_checks++; if (wb_cyc_o !== 1'b1 || wb_sel_o !== 4'b0011) begin n_fail++; $display("FAIL fl_hold: cyc %b sel %b want 1/0011", wb_cyc_o, wb_sel_o); end
      wb_ack_i = 1'b1; wb_dat_i = 32'hBAD0_BAD0;
      @(negedge clk);  // DONE
      wb_ack_i = 1'b0;
      n_checks++; if (m_ack !== '0 || m_err !== '0 || m_rdata !== '0) begin n_fail++; $display("FAIL fl_suppress: ack %b err %b rdata %h want 000/000/0", m_ack, m_err, m_rdata); end
      n_checks++; if (wb_cyc_o !== 1'b0 || m_stall !== 3'b010) begin n_fail++; $display("FAIL fl_done: cyc %b stall %b want 0/010", wb_cyc_o, m_stall); end
      pend = '0; pend[0] = 1'b1; t_we[0] = 1'b0; t_adr[0] = 32'h0000_0400; t_sel[0] = 4'hF;
      drive_masters();
      @(negedge clk);  // IDLE
      n_checks++; if (wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL fl_gap: got %b want 0", wb_cyc_o); end
      @(negedge clk);  // BUS
      n_checks++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h0000_0400) begin n_fail++; $display("FAIL fl_next: cyc %b adr %h want 1/00000400", wb_cyc_o, wb_adr_o); end
      wb_ack_i = 1'b1; wb_dat_i = 32'h600D_F00D;
      @(negedge clk);  // DONE
      wb_ack_i = 1'b0;
      n_checks++; if (m_ack !== 3'b001 || m_rdata !== 32'h600D_F00D) begin n_fail++; $display("FAIL fl_next_ack: ack %b rdata %h want 001/600df00d", m_ack, m_rdata); end
      pend = '0; drive_masters();
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      pend = '0; pend[0] = 1'b1; t_we[0] = 1'b1; t_adr[0] = 32'h0000_0500; t_dat[0] = 32'hA5A5_5A5A; t_sel[0] = 4'hF;
      drive_masters();
      @(negedge clk);  // BUS 1
      n_checks++; if (wb_cyc_o !== 1'b1) begin n_fail++; $display("FAIL rm_bus: got %b want 1", wb_cyc_o); end
      @(negedge clk);  // BUS 2
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000 || {wb_adr_o, wb_dat_o, wb_sel_o} !== '0) begin n_fail++; $display("FAIL rm_bus_out: ctl %b adr %h dat %h sel %b want 0", {wb_cyc_o, wb_stb_o, wb_we_o}, wb_adr_o, wb_dat_o, wb_sel_o); end
      n_checks++; if ({m_rdata, m_ack, m_err} !== '0) begin n_fail++; $display("FAIL rm_resp: rdata %h ack %b err %b want 0", m_rdata, m_ack, m_err); end
      rst = 1'b0; pend = '0; drive_masters();
      wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_0000;
      @(negedge clk);
      wb_ack_i = 1'b0;
      n_checks++; if (m_ack !== '0 || m_rdata !== '0 || wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rm_late_ack: ack %b rdata %h cyc %b want 000/0/0", m_ack, m_rdata, wb_cyc_o); end
      last_g = N_MST - 1;
      model_rdata = '0;
   endtask

   task automatic test_random();
      int               g, k, fc, j_end;
      bit               acked, cancel;
      logic [DW-1:0]    rd;
      logic [N_MST-1:0] exp_ack, exp_err;
      do_reset();
      for (int n = 0; n < 60; n++) begin
         // DUT idle here; flush and ack must both be ignored in this cycle.
         for (int i = 0; i < N_MST; i++) if (!pend[i] && $urandom_range(0, 2) != 0) new_txn(i);
         drive_masters();
         flush_i  = ($urandom_range(0, 3) == 0);
         wb_ack_i = ($urandom_range(0, 3) == 0);
         wb_dat_i = $urandom;
         if (pend == '0) begin
            @(negedge clk);
            n_checks++; if (wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rnd_idle%0d: got %b want 0", n, wb_cyc_o); end
         end else begin
            g = model_pick(pend);
            last_g = g;
            // First iterations pin the boundary: ack exactly at TIMEOUT, then one past it.
            k = (n < 4) ? TIMEOUT + (n % 2) : $urandom_range(1, TIMEOUT + 2);
            j_end  = (k <= TIMEOUT) ? k : TIMEOUT;
            fc     = ($urandom_range(0, 4) == 0) ? $urandom_range(1, j_end) : 0;
            acked  = (k <= TIMEOUT);
            cancel = (fc != 0);
            rd     = $urandom;
            @(negedge clk);  // BUS cycle 1
            n_checks++; if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || wb_we_o !== t_we[g] || wb_adr_o !== t_adr[g] || wb_dat_o !== t_dat[g] || wb_sel_o !== t_sel[g]) begin
               n_fail++; $display("FAIL rnd_grant%0d: cyc %b we %b adr %h dat %h sel %b want 1/%b/%h/%h/%b (master %0d)", n, wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, t_we[g], t_adr[g], t_dat[g], t_sel[g], g);
            end
            for (int j = 1; j <= j_end; j++) begin
               wb_ack_i = (j == k);
               wb_dat_i = (j == k) ? rd : $urandom;
               flush_i  = (j == fc);
               if (j == 1) begin
                  for (int i = 0; i < N_MST; i++) if (!pend[i] && $urandom_range(0, 1) != 0) new_txn(i);
                  drive_masters();
               end
               @(negedge clk);
               if (j < j_end) begin
                  n_checks++; if (wb_cyc_o !== 1'b1 || m_ack !== '0 || m_err !== '0 || wb_adr_o !== t_adr[g]) begin n_fail++; $display("FAIL rnd_busy%0d_%0d: cyc %b ack %b err %b adr %h want 1/000/000/%h", n, j, wb_cyc_o, m_ack, m_err, wb_adr_o, t_adr[g]); end
               end
            end
            // DONE cycle
            exp_ack = '0; exp_err = '0;
            if (!cancel) begin
               if (acked) exp_ack[g] = 1'b1;
               else       exp_err[g] = 1'b1;
            end
            n_checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin n_fail++; $display("FAIL rnd_drop%0d: cyc %b stb %b want 0/0", n, wb_cyc_o, wb_stb_o); end
            n_checks++; if (m_ack !== exp_ack || m_err !== exp_err) begin n_fail++; $display("FAIL rnd_resp%0d: ack %b err %b want %b/%b", n, m_ack, m_err, exp_ack, exp_err); end
            n_checks++; if (m_stall !== (pend & ~exp_ack & ~exp_err)) begin n_fail++; $display("FAIL rnd_stall%0d: got %b want %b", n, m_stall, pend & ~exp_ack & ~exp_err); end
            if (acked && !cancel) begin
               model_rdata = rd;
               exp_q.push_back(rd);
            end
            if (m_ack !== '0) begin
               n_checks++;
               if (exp_q.size() == 0) begin n_fail++; $display("FAIL rnd_sb%0d: unexpected ack, rdata %h", n, m_rdata); end
               else begin
                  rd = exp_q.pop_front();
                  if (m_rdata !== rd) begin n_fail++; $display("FAIL rnd_sb%0d: rdata %h want %h", n, m_rdata, rd); end
               end
            end
            n_checks++; if (m_rdata !== model_rdata) begin n_fail++; $display("FAIL rnd_rdata%0d: got %h want %h", n, m_rdata, model_rdata); end
            pend[g] = 1'b0;
            drive_masters();
            wb_ack_i = !acked && ($urandom_range(0, 1) != 0);  // stray ack after a timeout
            wb_dat_i = $urandom;
            flush_i  = ($urandom_range(0, 2) == 0);
            @(negedge clk);  // IDLE
            n_checks++; if (m_ack !== '0 || m_err !== '0 || wb_cyc_o !== 1'b0 || m_rdata !== model_rdata) begin n_fail++; $display("FAIL rnd_gap%0d: ack %b err %b cyc %b rdata %h want 000/000/0/%h", n, m_ack, m_err, wb_cyc_o, m_rdata, model_rdata); end
         end
      end
      flush_i = 1'b0; wb_ack_i = 1'b0; pend = '0; drive_masters();
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_sb_left: %0d entries want 0", exp_q.size()); end
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      for (int i = 0; i < N_MST; i++) begin
         t_we[i] = 1'b0; t_adr[i] = '0; t_dat[i] = '0; t_sel[i] = '0;
      end
      drive_masters();
      test_reset();
      test_single_read();
      test_contention();
      test_timeout();
      test_flush();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_arbiter_rr.md
WB_ARBITER_RR -- requirements
Module: wb_arbiter_rr

Interface
REQ-001 Parameter N_MST, default 2, number of requesting masters (2..8); index 0 = instruction fetch, 1 = data memory.
REQ-002 Parameter DW, default 32, data width; a multiple of 8. SW = DW/8.
REQ-003 Parameter AW, default 32, address width.
REQ-004 Parameter TIMEOUT, default 255, maximum cycles to wait for ack_i; range 1..65535.
REQ-005 Port clk  input  1  clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  reset; synchronous, active-high.
REQ-007 Port flush_i  input  1  pipeline flush; discards the in-flight response.
REQ-008 Port m_req  input  N_MST  per-master request, held high until m_ack or m_err.
REQ-009 Port m_we  input  N_MST  per-master write enable.
REQ-010 Port m_addr  input  N_MST*AW  packed addresses, master i at [i*AW +: AW].
REQ-011 Port m_wdata  input  N_MST*DW  packed write data.
REQ-012 Port m_sel  input  N_MST*SW  packed byte selects.
REQ-013 Port m_rdata  output  DW  registered read data, valid while m_ack is high.
REQ-014 Port m_ack  output  N_MST  one-hot, one-cycle completion pulse.
REQ-015 Port m_err  output  N_MST  one-hot, one-cycle timeout pulse.
REQ-016 Port m_stall  output  N_MST  m_stall[i] = m_req[i] & ~m_ack[i] & ~m_err[i]; combinational.
REQ-017 Ports wb_cyc_o, wb_stb_o, wb_we_o  output  1  Wishbone cycle, strobe and write enable; registered.
REQ-018 Ports wb_adr_o  output  AW, wb_dat_o  output  DW, wb_sel_o  output  SW  Wishbone address, write data and select; registered.
REQ-019 Ports wb_dat_i  input  DW, wb_ack_i  input  1  Wishbone read data and acknowledge.

Function
REQ-020 The FSM SHALL have three states. IDLE: no bus cycle. BUS: cyc and stb high. DONE: one-cycle gap after a cycle ends.
REQ-021 In IDLE with any m_req high, the FSM SHALL latch the winner g and its we/addr/wdata/sel, assert wb_cyc_o/wb_stb_o on the next cycle, and enter BUS.
REQ-022 In BUS, on wb_ack_i, the FSM SHALL:
- deassert cyc/stb on the next cycle;
- register wb_dat_i into m_rdata;
- pulse m_ack[g] for one cycle;
- enter DONE.
REQ-023 The latency from m_req rising in IDLE to wb_stb_o is 1 cycle; from wb_ack_i to m_ack is 1 cycle.
REQ-024 In BUS, a wait counter SHALL increment each cycle without ack. When it reaches TIMEOUT, the FSM SHALL:
- drop cyc/stb;
- pulse m_err[g] (not m_ack);
- enter DONE.
REQ-025 wb_ack_i arriving in the same cycle the counter reaches TIMEOUT SHALL count as an ack; no m_err.
REQ-026 DONE SHALL always return to IDLE after one cycle, so back-to-back grants are separated by one idle bus cycle.
REQ-027 flush_i high in any cycle of BUS SHALL set a cancel flag. The bus cycle SHALL still complete normally, but the m_ack/m_err pulse SHALL be suppressed and m_rdata left unchanged.
REQ-028 flush_i in IDLE or DONE SHALL have no effect; the cancel flag SHALL clear on entry to IDLE.
REQ-029 wb_ack_i in IDLE or DONE SHALL be ignored.
REQ-030 m_req changes during BUS SHALL NOT affect the latched transaction; a master that drops m_req mid-cycle still completes on the bus with its response discarded.
REQ-031 Address, data and select SHALL pass through unchanged at width AW/DW/SW; there is no byte merging.

Reset
REQ-032 While rst is high at a clock edge:
- state = IDLE; counter = 0; cancel = 0; round-robin pointer = N_MST-1;
- wb_cyc_o, wb_stb_o, wb_we_o = 0; wb_adr_o, wb_dat_o, wb_sel_o = 0;
- m_rdata = 0; m_ack = 0; m_err = 0.
REQ-033 rst during BUS SHALL abort immediately: cyc = 0 on the next cycle, with no ack/err pulse.

Configuration
REQ-034 With macro WB_ARB_ROUND_ROBIN_EN defined, the grant SHALL go to the first requester after the last granted index, searching upward with wrap-around. The pointer updates to g on each grant.
REQ-035 Without WB_ARB_ROUND_ROBIN_EN, the grant SHALL go to the lowest-indexed requester (fixed priority), and no pointer register exists.

Verification
REQ-036 Single read: m_req=01, addr 0x100; slave acks after 3 cycles with 0xDEADBEEF -> stb high at cycle 1, m_ack=01 at cycle 5, m_rdata=0xDEADBEEF.
REQ-037 Contention, round-robin build: m_req=11 held for 4 transactions -> grant order 0,1,0,1. Fixed-priority build: order 0,0,0,0.
REQ-038 Timeout: TIMEOUT=4, slave never acks -> cyc high for 4 cycles, then m_err[g] pulses, m_ack stays 0.
REQ-039 Flush: flush_i pulsed during BUS of a master-1 write with sel 0011 -> bus write completes with sel 0011, no m_ack, and the next grant proceeds normally.
REQ-040 Reset mid-cycle: rst asserted in the second BUS cycle -> cyc = 0 the next cycle, all outputs 0, and a later ack is ignored.
